// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared constants and types for the SPI command sequencer
//
// Purpose: command-word layout, opcode values and the sequencer state
// encoding, shared by the sequencer and anything that builds command words.
// Ports: none (package).

package spi_cmd_pkg;

  // Command word layout: [15:8] opcode, [7:0] argument (data byte or delay).
  localparam int CMD_W   = 16;
  localparam int OP_LSB  = 8;
  localparam int ARG_LSB = 0;
  localparam int ARG_W   = 8;

  localparam logic [7:0] OP_DATA   = 8'h00;
  localparam logic [7:0] OP_CS_ON  = 8'h01;
  localparam logic [7:0] OP_CS_OFF = 8'h02;
  localparam logic [7:0] OP_DELAY  = 8'h03;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    DELAY = 3'd4
  } state_t;

endpackage

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command FIFO to SPI byte-engine sequencer
//
// Purpose: pops 16-bit command words from a show-ahead FIFO and executes them:
// DATA words become one-byte engine transfers whose received byte is pushed
// into a result FIFO; CS_ON/CS_OFF drive a manual chip-select; DELAY idles
// for arg+1 cycles; unknown opcodes set a sticky error and are discarded.
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   enable             allows new command fetches (sampled in IDLE only)
//   cmd_data/empty/rd  command FIFO head, empty flag, pop strobe
//   res_data/wr/full   result FIFO write data, push strobe, full flag
//   eng_go/data        engine start pulse and byte to transmit
//   eng_done/result    engine completion pulse and received byte
//   cs_active          manual chip-select request
//   busy               high whenever a command is executing
//   err_opcode         sticky unknown-opcode flag
//   tx_count           completed data transfers, wraps

module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int OP_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             cmd_empty,
  output logic             cmd_rd,
  output logic [7:0]       res_data,
  output logic             res_wr,
  input  logic             res_full,
  output logic             eng_go,
  output logic [7:0]       eng_data,
  input  logic             eng_done,
  input  logic [7:0]       eng_result,
  output logic             cs_active,
  output logic             busy,
  output logic             err_opcode,
  output logic [CNT_W-1:0] tx_count
);

  state_t state_q, state_d;

  logic [OP_W-1:0]  opcode;
  logic [ARG_W-1:0] arg;
  // Only the argument byte of a popped word is needed after the pop edge;
  // the opcode is fully decoded in IDLE.
  logic [ARG_W-1:0] cmd_arg_q;
  logic [7:0]       res_reg_q;
  logic [ARG_W-1:0] cnt_q;
  logic             cs_q;
  logic             err_q;
  logic [CNT_W-1:0] tx_count_q;

  assign opcode = cmd_data[OP_LSB +: OP_W];
  assign arg    = cmd_data[ARG_LSB +: ARG_W];

  // Gated by reset so no pop strobe can reach the FIFO while held in reset.
  assign cmd_rd = reset && (state_q == IDLE) && enable && !cmd_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_rd) begin
          case (opcode)
            OP_DATA:  state_d = GO;
            OP_DELAY: state_d = DELAY;
            default:  state_d = IDLE;
          endcase
        end
      end
      GO:      state_d = WAIT;
      WAIT:    if (eng_done) state_d = STORE;
      STORE:   if (!res_full) state_d = IDLE;
      DELAY:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_arg_q  <= '0;
      res_reg_q  <= '0;
      cnt_q      <= '0;
      cs_q       <= 1'b0;
      err_q      <= 1'b0;
      tx_count_q <= '0;
    end else begin
      if (cmd_rd) begin
        cmd_arg_q <= arg;
        // CS and error side effects land on the pop edge itself, so these
        // words never leave IDLE and can be popped back to back.
        case (opcode)
          OP_DATA:   begin end
          OP_CS_ON:  cs_q  <= 1'b1;
          OP_CS_OFF: cs_q  <= 1'b0;
          OP_DELAY:  cnt_q <= arg;
          default:   err_q <= 1'b1;
        endcase
      end else if ((state_q == DELAY) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - ARG_W'(1);
      end

      if ((state_q == WAIT) && eng_done) begin
        res_reg_q <= eng_result;
      end

      if (res_wr) begin
        tx_count_q <= tx_count_q + CNT_W'(1);
      end
    end
  end

  assign eng_go     = (state_q == GO);
  assign eng_data   = cmd_arg_q;
  // The result is held in res_reg_q, so a full result FIFO only delays the push.
  assign res_wr     = (state_q == STORE) && !res_full;
  assign res_data   = res_reg_q;
  assign cs_active  = cs_q;
  assign busy       = (state_q != IDLE);
  assign err_opcode = err_q;
  assign tx_count   = tx_count_q;

endmodule
